// File: rtl/signal_freq_meter.sv
// Frequency and peak-amplitude meter for the DDS sample stream: Schmitt zero-crossing
// detector feeding a saturating edge counter that is latched at the end of each gate window.
module signal_freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter logic [15:0] HYST        = 16'd1024,
  parameter int unsigned OUT_W       = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      SignalIn,
  input  logic             Enable,
  output logic [OUT_W-1:0] FreqOut,
  output logic             FreqValid,
  output logic [15:0]      AmpMax,
  output logic [15:0]      AmpMin,
  output logic             Overflow
);

  localparam int unsigned GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GateLast = GW'(GATE_CYCLES - 1);

  // Thresholds computed one bit wide and clamped so extreme HYST values stay in range.
  localparam logic [16:0] HiSum  = 17'h08000 + {1'b0, HYST};
  localparam logic [16:0] LoDiff = 17'h08000 - {1'b0, HYST};
  localparam logic [15:0] ThrHi  = HiSum[16] ? 16'hFFFF : HiSum[15:0];
  localparam logic [15:0] ThrLo  = LoDiff[16] ? 16'h0000 : LoDiff[15:0];

  typedef enum logic {StLow, StHigh} schmitt_e;

  schmitt_e         state;
  logic [15:0]      sreg;
  logic [GW-1:0]    gate_cnt;
  logic [OUT_W-1:0] edge_cnt;
  logic             sat_flag;
  logic [15:0]      run_max;
  logic [15:0]      run_min;

  logic             rise;
  logic [OUT_W:0]   cnt_sum;
  logic [OUT_W-1:0] cnt_sat;
  logic [15:0]      next_max;
  logic [15:0]      next_min;
  logic             gate_close;

  always_comb begin
    rise       = (state == StLow) && (sreg >= ThrHi);
    cnt_sum    = {1'b0, edge_cnt} + {{OUT_W{1'b0}}, rise};
    cnt_sat    = cnt_sum[OUT_W] ? {OUT_W{1'b1}} : cnt_sum[OUT_W-1:0];
    next_max   = (sreg > run_max) ? sreg : run_max;
    next_min   = (sreg < run_min) ? sreg : run_min;
    gate_close = Enable && (gate_cnt == GateLast);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg      <= 16'h0000;
      state     <= StLow;
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      sat_flag  <= 1'b0;
      run_max   <= 16'h0000;
      run_min   <= 16'hFFFF;
      FreqOut   <= '0;
      FreqValid <= 1'b0;
      AmpMax    <= 16'h0000;
      AmpMin    <= 16'h0000;
      Overflow  <= 1'b0;
    end else begin
      sreg      <= SignalIn;
      FreqValid <= 1'b0;

      // Detector keeps tracking while disabled so the first gate sees a settled state.
      case (state)
        StLow:   if (sreg >= ThrHi) state <= StHigh;
        StHigh:  if (sreg <= ThrLo) state <= StLow;
        default: state <= StLow;
      endcase

      if (!Enable) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat_flag <= 1'b0;
        run_max  <= 16'h0000;
        run_min  <= 16'hFFFF;
      end else if (gate_close) begin
        // The close-cycle sample and edge belong to the gate being closed.
        FreqOut   <= cnt_sat;
        Overflow  <= sat_flag | cnt_sum[OUT_W];
        AmpMax    <= next_max;
        AmpMin    <= next_min;
        FreqValid <= 1'b1;
        gate_cnt  <= '0;
        edge_cnt  <= '0;
        sat_flag  <= 1'b0;
        run_max   <= 16'h0000;
        run_min   <= 16'hFFFF;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= cnt_sat;
        sat_flag <= sat_flag | cnt_sum[OUT_W];
        run_max  <= next_max;
        run_min  <= next_min;
      end
    end
  end

endmodule

// File: tb/tb_signal_freq_meter.sv
// Bench for signal_freq_meter: a 21-bit and an 8-bit instance share stimulus; expected gate
// results are queued as each gate window's last sample is driven and checked on FreqValid.
module tb_signal_freq_meter;

  typedef struct packed {
    logic [20:0] freq;
    logic        ovf;
    logic [15:0] amax;
    logic [15:0] amin;
  } res_t;

  typedef struct {
    int        at;
    res_t      r;
    logic [7:0] f8;
    logic      o8;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] SignalIn;
  logic        Enable;
  logic [20:0] FreqOut;
  logic        FreqValid;
  logic [15:0] AmpMax, AmpMin;
  logic        Overflow;
  logic [7:0]  FreqOut8;
  logic        FreqValid8;
  logic [15:0] AmpMax8, AmpMin8;
  logic        Overflow8;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  signal_freq_meter #(.GATE_CYCLES(1000), .HYST(16'd1024), .OUT_W(21)) u_dut (
    .clk(clk), .reset(reset), .SignalIn(SignalIn), .Enable(Enable),
    .FreqOut(FreqOut), .FreqValid(FreqValid), .AmpMax(AmpMax), .AmpMin(AmpMin),
    .Overflow(Overflow)
  );

  signal_freq_meter #(.GATE_CYCLES(1000), .HYST(16'd1024), .OUT_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .SignalIn(SignalIn), .Enable(Enable),
    .FreqOut(FreqOut8), .FreqValid(FreqValid8), .AmpMax(AmpMax8), .AmpMin(AmpMin8),
    .Overflow(Overflow8)
  );

  function automatic logic [15:0] sq(input int n);
    return (((n + 10000) % 10) < 5) ? 16'h0000 : 16'hFFFF;
  endfunction

  function automatic exp_t mk(input int at, input int f, input logic ovf, input logic [15:0] mx,
                              input logic [15:0] mn, input int f8, input logic o8);
    exp_t e;
    e.at = at;
    e.r  = {21'(f), ovf, mx, mn};
    e.f8 = 8'(f8);
    e.o8 = o8;
    return e;
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (FreqOut !== 21'd0) begin bad++; $display("FAIL reset_freq: got %0d, required 0", FreqOut); end
    total++;
    if (FreqValid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", FreqValid); end
    total++;
    if (AmpMax !== 16'h0000) begin bad++; $display("FAIL reset_max: got %h, required 0000", AmpMax); end
    total++;
    if (AmpMin !== 16'h0000) begin bad++; $display("FAIL reset_min: got %h, required 0000", AmpMin); end
    total++;
    if (Overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b, required 0", Overflow); end
    total++;
    if ({FreqOut8, FreqValid8, AmpMax8, AmpMin8, Overflow8} !== 42'd0) begin
      bad++; $display("FAIL reset_dut8: got freq=%0d valid=%b max=%h min=%h ovf=%b, required all 0",
                      FreqOut8, FreqValid8, AmpMax8, AmpMin8, Overflow8);
    end
    reset = 1'b1;
  endtask

  task automatic test_square();
    exp_t e;
    for (int n = -20; n <= 3001; n++) begin
      @(negedge clk);
      if (FreqValid || FreqValid8) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL square_pulse: pulse at n=%0d, required none", n);
        end else begin
          e = q.pop_front();
          if ({FreqOut, Overflow, AmpMax, AmpMin} !== e.r || n != e.at) begin
            bad++; $display("FAIL square_result: got freq=%0d ovf=%b max=%h min=%h at n=%0d, required freq=%0d ovf=%b max=%h min=%h at n=%0d",
                            FreqOut, Overflow, AmpMax, AmpMin, n, e.r.freq, e.r.ovf, e.r.amax, e.r.amin, e.at);
          end
          total++;
          if ({FreqValid8, FreqOut8, Overflow8} !== {1'b1, e.f8, e.o8}) begin
            bad++; $display("FAIL square_dut8: got valid=%b freq=%0d ovf=%b, required 1 %0d %b",
                            FreqValid8, FreqOut8, Overflow8, e.f8, e.o8);
          end
        end
      end
      SignalIn = sq(n);
      Enable   = (n >= 0);
      if (n >= 0 && n < 3000 && n % 1000 == 998) q.push_back(mk(n + 2, 100, 1'b0, 16'hFFFF, 16'h0000, 100, 1'b0));
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL square_missing: %0d pulses outstanding, required 0", q.size()); end
    q.delete();
  endtask

  task automatic test_noise();
    exp_t e;
    logic [15:0] s, wmax, wmin;
    wmax = 16'h0000;
    wmin = 16'hFFFF;
    for (int n = -5; n <= 3001; n++) begin
      @(negedge clk);
      if (FreqValid || FreqValid8) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL noise_pulse: pulse at n=%0d, required none", n);
        end else begin
          e = q.pop_front();
          if ({FreqOut, Overflow, AmpMax, AmpMin} !== e.r || n != e.at) begin
            bad++; $display("FAIL noise_result: got freq=%0d ovf=%b max=%h min=%h at n=%0d, required freq=%0d ovf=%b max=%h min=%h at n=%0d",
                            FreqOut, Overflow, AmpMax, AmpMin, n, e.r.freq, e.r.ovf, e.r.amax, e.r.amin, e.at);
          end
          total++;
          if ({FreqValid8, FreqOut8, Overflow8} !== {1'b1, e.f8, e.o8}) begin
            bad++; $display("FAIL noise_dut8: got valid=%b freq=%0d ovf=%b, required 1 %0d %b",
                            FreqValid8, FreqOut8, Overflow8, e.f8, e.o8);
          end
          total++;
          if (AmpMax > 16'h81F4 || AmpMin < 16'h7E0C) begin
            bad++; $display("FAIL noise_range: got max=%h min=%h, required max<=81f4 min>=7e0c", AmpMax, AmpMin);
          end
        end
      end
      s = 16'(32'h8000 + $urandom_range(1000) - 500);
      SignalIn = s;
      Enable   = (n >= 0);
      if (n >= -1 && n <= 2998) begin
        if ((n + 1) % 1000 == 0) begin wmax = 16'h0000; wmin = 16'hFFFF; end
        if (s > wmax) wmax = s;
        if (s < wmin) wmin = s;
        if ((n + 1) % 1000 == 999) q.push_back(mk(n + 2, 0, 1'b0, wmax, wmin, 0, 1'b0));
      end
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL noise_missing: %0d pulses outstanding, required 0", q.size()); end
    q.delete();
  endtask

  task automatic test_close_edge();
    exp_t e;
    for (int n = -5; n <= 2001; n++) begin
      @(negedge clk);
      if (FreqValid || FreqValid8) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL close_pulse: pulse at n=%0d, required none", n);
        end else begin
          e = q.pop_front();
          if ({FreqOut, Overflow, AmpMax, AmpMin} !== e.r || n != e.at) begin
            bad++; $display("FAIL close_result: got freq=%0d ovf=%b max=%h min=%h at n=%0d, required freq=%0d ovf=%b max=%h min=%h at n=%0d",
                            FreqOut, Overflow, AmpMax, AmpMin, n, e.r.freq, e.r.ovf, e.r.amax, e.r.amin, e.at);
          end
          total++;
          if ({FreqValid8, FreqOut8, Overflow8} !== {1'b1, e.f8, e.o8}) begin
            bad++; $display("FAIL close_dut8: got valid=%b freq=%0d ovf=%b, required 1 %0d %b",
                            FreqValid8, FreqOut8, Overflow8, e.f8, e.o8);
          end
        end
      end
      // Sample 998 is the close-cycle Sreg value of the first gate.
      SignalIn = (n >= 998) ? 16'hFFFF : 16'h0000;
      Enable   = (n >= 0);
      if (n == 998)  q.push_back(mk(n + 2, 1, 1'b0, 16'hFFFF, 16'h0000, 1, 1'b0));
      if (n == 1998) q.push_back(mk(n + 2, 0, 1'b0, 16'hFFFF, 16'hFFFF, 0, 1'b0));
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL close_missing: %0d pulses outstanding, required 0", q.size()); end
    q.delete();
  endtask

  task automatic test_overflow();
    exp_t e;
    for (int n = -4; n <= 2001; n++) begin
      @(negedge clk);
      if (FreqValid || FreqValid8) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL ovf_pulse: pulse at n=%0d, required none", n);
        end else begin
          e = q.pop_front();
          if ({FreqOut, Overflow, AmpMax, AmpMin} !== e.r || n != e.at) begin
            bad++; $display("FAIL ovf_result: got freq=%0d ovf=%b max=%h min=%h at n=%0d, required freq=%0d ovf=%b max=%h min=%h at n=%0d",
                            FreqOut, Overflow, AmpMax, AmpMin, n, e.r.freq, e.r.ovf, e.r.amax, e.r.amin, e.at);
          end
          total++;
          if ({FreqValid8, FreqOut8, Overflow8} !== {1'b1, e.f8, e.o8}) begin
            bad++; $display("FAIL ovf_dut8: got valid=%b freq=%0d ovf=%b, required 1 %0d %b",
                            FreqValid8, FreqOut8, Overflow8, e.f8, e.o8);
          end
        end
      end
      // Odd samples high: 500 crossings in gate 0, ten (999..1017) in gate 1.
      SignalIn = ((n & 1) != 0 && n < 1018) ? 16'hFFFF : 16'h0000;
      Enable   = (n >= 0);
      if (n == 998)  q.push_back(mk(n + 2, 500, 1'b0, 16'hFFFF, 16'h0000, 255, 1'b1));
      if (n == 1998) q.push_back(mk(n + 2, 10, 1'b0, 16'hFFFF, 16'h0000, 10, 1'b0));
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL ovf_missing: %0d pulses outstanding, required 0", q.size()); end
    q.delete();
  endtask

  task automatic test_enable_drop();
    exp_t e;
    for (int n = -20; n <= 1700; n++) begin
      @(negedge clk);
      if (FreqValid || FreqValid8) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL drop_pulse: pulse at n=%0d, required none", n);
        end else begin
          e = q.pop_front();
          if ({FreqOut, Overflow, AmpMax, AmpMin} !== e.r || n != e.at) begin
            bad++; $display("FAIL drop_result: got freq=%0d ovf=%b max=%h min=%h at n=%0d, required freq=%0d ovf=%b max=%h min=%h at n=%0d",
                            FreqOut, Overflow, AmpMax, AmpMin, n, e.r.freq, e.r.ovf, e.r.amax, e.r.amin, e.at);
          end
          total++;
          if ({FreqValid8, FreqOut8, Overflow8} !== {1'b1, e.f8, e.o8}) begin
            bad++; $display("FAIL drop_dut8: got valid=%b freq=%0d ovf=%b, required 1 %0d %b",
                            FreqValid8, FreqOut8, Overflow8, e.f8, e.o8);
          end
        end
      end
      SignalIn = sq(n);
      Enable   = (n >= 0 && n < 600) || (n >= 650);
      if (n == 1648) q.push_back(mk(n + 2, 100, 1'b0, 16'hFFFF, 16'h0000, 100, 1'b0));
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL drop_missing: %0d pulses outstanding, required 0", q.size()); end
    q.delete();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int n = -5; n <= 1450; n++) begin
      @(negedge clk);
      if (FreqValid || FreqValid8) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rstmid_pulse: pulse at n=%0d, required none", n);
        end else begin
          e = q.pop_front();
          if ({FreqOut, Overflow, AmpMax, AmpMin} !== e.r || n != e.at) begin
            bad++; $display("FAIL rstmid_result: got freq=%0d ovf=%b max=%h min=%h at n=%0d, required freq=%0d ovf=%b max=%h min=%h at n=%0d",
                            FreqOut, Overflow, AmpMax, AmpMin, n, e.r.freq, e.r.ovf, e.r.amax, e.r.amin, e.at);
          end
          total++;
          if ({FreqValid8, FreqOut8, Overflow8} !== {1'b1, e.f8, e.o8}) begin
            bad++; $display("FAIL rstmid_dut8: got valid=%b freq=%0d ovf=%b, required 1 %0d %b",
                            FreqValid8, FreqOut8, Overflow8, e.f8, e.o8);
          end
        end
      end
      if (n == 400) begin
        reset = 1'b0;
        #1;
        total++;
        if ({FreqOut, FreqValid, AmpMax, AmpMin, Overflow} !== 55'd0) begin
          bad++; $display("FAIL rstmid_clear: got freq=%0d valid=%b max=%h min=%h ovf=%b, required all 0",
                          FreqOut, FreqValid, AmpMax, AmpMin, Overflow);
        end
        total++;
        if ({FreqOut8, FreqValid8, AmpMax8, AmpMin8, Overflow8} !== 42'd0) begin
          bad++; $display("FAIL rstmid_clear8: got freq=%0d valid=%b max=%h min=%h ovf=%b, required all 0",
                          FreqOut8, FreqValid8, AmpMax8, AmpMin8, Overflow8);
        end
      end
      if (n == 403) reset = 1'b1;
      SignalIn = (n < 395) ? sq(n) : 16'hFFFF;
      Enable   = (n >= 0);
      // Detector restarts LOW with Sreg=0, so the held-high input gives exactly one crossing.
      if (n == 1401) q.push_back(mk(n + 2, 1, 1'b0, 16'hFFFF, 16'h0000, 1, 1'b0));
    end
    total++;
    if (q.size() != 0) begin bad++; $display("FAIL rstmid_missing: %0d pulses outstanding, required 0", q.size()); end
    q.delete();
  endtask

  initial begin
    reset    = 1'b0;
    Enable   = 1'b0;
    SignalIn = 16'hFFFF;
    test_reset();
    test_square();
    test_noise();
    test_close_edge();
    test_overflow();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
